// File: rtl/pipeline_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the fetch/execute memory arbiter.
//   - arb_state_t : arbiter slot state (idle, fetch read in flight, data read
//                   in flight)
//   - arb_req_t   : which requester owns the current access slot
//   - MEM_LAT_MAX : largest supported memory read latency
//   - LAT_W       : width of the read-latency down-counter
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_IF = 2'd1,
    ARB_RD_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } arb_req_t;

  // Fetch accesses are always reads; data accesses are reads unless d_we.
  function automatic logic is_read(arb_req_t winner, logic d_we);
    return (winner == REQ_IF) || !d_we;
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pipeline_mem_arbiter_if
//   Request/response bundle between the pipeline stages and the arbiter.
//   Fetch side : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   modport master : the CPU stages (drive requests, receive grants/data)
//   modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata
  );

endinterface

// File: rtl/pipeline_mem_arbiter_mem_busy_counter.sv
// -----------------------------------------------------------------------------
// mem_busy_counter
//   Loadable down-counter tracking the remaining cycles of an outstanding
//   memory read. Counts down to zero and stops there.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : latency to load
//   count      : current value
//   zero       : count == 0 (no read outstanding)
//   last       : count == 1 (final cycle of the outstanding read)
// -----------------------------------------------------------------------------
module mem_busy_counter
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             zero,
  output logic             last
);

  // NOTE: clocked state uses non-blocking <= so every flop samples the
  // pre-edge values, independent of statement or process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - LAT_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == LAT_W'(1));

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipeline_mem_arbiter
//   Shares one single-ported synchronous memory between instruction fetch and
//   the execute-stage load/store unit. One access is granted per slot; a slot
//   opens when nothing is outstanding or in the last cycle of a read, so reads
//   issue back-to-back. Data wins contention unless fetch has been passed over
//   STARVE_MAX times in a row.
//
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : fetch and data request/grant/response signals
//   mem_addr     : memory address (0 when no access is granted)
//   mem_wdata    : memory write data (0 unless a data access is granted)
//   mem_we       : memory write strobe
//   mem_re       : memory read strobe
//   mem_rdata    : memory read data, valid MEM_LAT cycles after mem_re
//   stall_fetch  : fetch waiting for grant or for its read data
//   stall_mem    : data access waiting for grant or for its load data
//
//   Parameters: ADDR_W, DATA_W, MEM_LAT (1..MEM_LAT_MAX), STARVE_MAX (>=1)
// -----------------------------------------------------------------------------
module pipeline_mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_mem_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_fetch,
  output logic                  stall_mem
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam int               SW       = $clog2(STARVE_MAX + 1);

  arb_state_t       state_q, state_d;
  arb_req_t         winner;
  logic [SW-1:0]    starve_q;
  logic             starve_full;
  logic             slot_open;
  logic             grant;
  logic             rd_grant;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_zero;
  logic             lat_last;

  mem_busy_counter u_busy (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_grant),
    .load_val (LAT_LOAD),
    .count    (lat_cnt),
    .zero     (lat_zero),
    .last     (lat_last)
  );

  // ---------------------------------------------------------------------------
  // Arbitration (combinational). Grants are suppressed while reset is held so
  // every output reads 0 during reset.
  // ---------------------------------------------------------------------------
  assign starve_full = (starve_q == SW'(STARVE_MAX));
  assign slot_open   = ~reset & (lat_zero | lat_last);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    winner = REQ_D;
    if (bus.if_req && (!bus.d_req || starve_full)) begin
      winner = REQ_IF;
    end
  end

  assign grant      = slot_open & (bus.if_req | bus.d_req);
  assign bus.if_gnt = grant & (winner == REQ_IF);
  assign bus.d_gnt  = grant & (winner == REQ_D);
  assign rd_grant   = grant & is_read(winner, bus.d_we);

  // Memory command follows the winner in the grant cycle; addresses are only
  // looked at here, so a changing or unknown address before grant is harmless.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (grant) begin
      if (winner == REQ_IF) begin
        mem_addr = bus.if_addr;
        mem_re   = 1'b1;
      end else begin
        mem_addr  = bus.d_addr;
        mem_wdata = bus.d_wdata;
        mem_we    = bus.d_we;
        mem_re    = ~bus.d_we;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot state. A read grant (re)loads the latency counter and records who
  // owns the returning data; stores never leave IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (lat_last) begin
      state_d = ARB_IDLE;
    end
    if (rd_grant) begin
      state_d = (winner == REQ_IF) ? ARB_RD_IF : ARB_RD_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts data grants that passed over a waiting fetch; any break in if_req
  // or a fetch grant restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!bus.if_req || bus.if_gnt) begin
      starve_q <= '0;
    end else if (bus.d_gnt && !starve_full) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: mem_rdata is passed straight through in the final latency
  // cycle. Reset drops an in-flight read, so its data never shows up.
  // ---------------------------------------------------------------------------
  assign bus.if_rvalid = ~reset & lat_last & (state_q == ARB_RD_IF);
  assign bus.d_rvalid  = ~reset & lat_last & (state_q == ARB_RD_D);
  assign bus.if_rdata  = bus.if_rvalid ? mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? mem_rdata : '0;

  assign stall_fetch = ~reset & ((bus.if_req & ~bus.if_gnt) |
                                 ((state_q == ARB_RD_IF) & ~bus.if_rvalid));
  assign stall_mem   = ~reset & ((bus.d_req & ~bus.d_gnt) |
                                 ((state_q == ARB_RD_D) & ~bus.d_rvalid));

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(bus.if_gnt && bus.d_gnt));

  a_one_strobe : assert property (@(posedge clk) disable iff (reset)
    !(mem_we && mem_re));

  a_no_early_grant : assert property (@(posedge clk) disable iff (reset)
    (lat_cnt > LAT_W'(1)) |-> !(bus.if_gnt || bus.d_gnt));

  a_idle_matches_counter : assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_IDLE) == lat_zero);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipeline_mem_arbiter
//   Three arbiter instances (MEM_LAT = 1, 3, 2) share one stimulus record.
//   A cycle-by-cycle vector table exercises the MEM_LAT=1 instance; short
//   hand-written sequences cover starvation-counter clearing, reset during a
//   long read and read/fetch overlap at MEM_LAT=2.
// -----------------------------------------------------------------------------
module tb_pipeline_mem_arbiter;

  typedef struct packed {
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        stall_fetch;
    logic        stall_mem;
  } out_t;

  typedef struct {
    string name;
    in_t   vin;
    out_t  vexp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  drv;
  out_t act [3];

  logic [15:0] mem_addr_w    [3];
  logic [15:0] mem_wdata_w   [3];
  logic        mem_we_w      [3];
  logic        mem_re_w      [3];
  logic        stall_fetch_w [3];
  logic        stall_mem_w   [3];

  pipeline_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].if_req  = drv.if_req;
    assign bus[g].if_addr = drv.if_addr;
    assign bus[g].d_req   = drv.d_req;
    assign bus[g].d_we    = drv.d_we;
    assign bus[g].d_addr  = drv.d_addr;
    assign bus[g].d_wdata = drv.d_wdata;
    assign act[g] = {bus[g].if_gnt, bus[g].d_gnt, bus[g].if_rvalid, bus[g].if_rdata,
                     bus[g].d_rvalid, bus[g].d_rdata, mem_addr_w[g], mem_wdata_w[g],
                     mem_we_w[g], mem_re_w[g], stall_fetch_w[g], stall_mem_w[g]};
  end

  pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
    .clk(clk), .reset(drv.reset), .bus(bus[0]),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_we(mem_we_w[0]),
    .mem_re(mem_re_w[0]), .mem_rdata(drv.mem_rdata),
    .stall_fetch(stall_fetch_w[0]), .stall_mem(stall_mem_w[0])
  );

  pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) dut_lat3 (
    .clk(clk), .reset(drv.reset), .bus(bus[1]),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_we(mem_we_w[1]),
    .mem_re(mem_re_w[1]), .mem_rdata(drv.mem_rdata),
    .stall_fetch(stall_fetch_w[1]), .stall_mem(stall_mem_w[1])
  );

  pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)) dut_lat2 (
    .clk(clk), .reset(drv.reset), .bus(bus[2]),
    .mem_addr(mem_addr_w[2]), .mem_wdata(mem_wdata_w[2]), .mem_we(mem_we_w[2]),
    .mem_re(mem_re_w[2]), .mem_rdata(drv.mem_rdata),
    .stall_fetch(stall_fetch_w[2]), .stall_mem(stall_mem_w[2])
  );

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [$bits(out_t)-1:0] actual,
                       input logic [$bits(out_t)-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic in_t mk_in(logic rst, logic ifr, logic [15:0] ifa, logic dr, logic dwe,
                                logic [15:0] da, logic [15:0] dwd, logic [15:0] mrd);
    in_t v;
    v.reset = rst;  v.if_req = ifr; v.if_addr = ifa; v.d_req = dr; v.d_we = dwe;
    v.d_addr = da;  v.d_wdata = dwd; v.mem_rdata = mrd;
    return v;
  endfunction

  // Argument order: if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
  // mem_addr, mem_wdata, mem_we, mem_re, stall_fetch, stall_mem
  function automatic out_t mk_out(logic ig, logic dg, logic ir, logic [15:0] ird, logic dv,
                                  logic [15:0] drd, logic [15:0] ma, logic [15:0] mwd,
                                  logic we, logic re, logic sf, logic sm);
    out_t o;
    o.if_gnt = ig;   o.d_gnt = dg;     o.if_rvalid = ir; o.if_rdata = ird;
    o.d_rvalid = dv; o.d_rdata = drd;  o.mem_addr = ma;  o.mem_wdata = mwd;
    o.mem_we = we;   o.mem_re = re;    o.stall_fetch = sf; o.stall_mem = sm;
    return o;
  endfunction

  task automatic add(input string n, input in_t vi, input out_t ve);
    vec_t v;
    v.name = n; v.vin = vi; v.vexp = ve;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, check the selected
  // instance's outputs 1 ns later; the rising edge then commits the cycle.
  task automatic step(input int sel, input string name, input in_t vi, input out_t ve);
    @(negedge clk);
    drv = vi;
    #1;
    check(name, act[sel], ve);
  endtask

  in_t both_ld;
  in_t idle_in;
  logic starve_if_pat [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic starve_exp_if [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    drv = '0;
    drv.reset = 1'b1;

    // ---------------- Vector table, MEM_LAT = 1 instance ----------------
    for (int i = 0; i < 3; i++)
      add($sformatf("reset_%0d", i),
          mk_in(1, 1, 16'h0010, 1, 0, 16'h0300, 16'h0000, 16'hA5A5), '0);

    add("fetch_grant", mk_in(0, 1, 16'h0010, 0, 0, 16'h0300, 16'h0000, 16'hA5A5),
        mk_out(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 16'h0000, 0, 1, 0, 0));
    add("fetch_rvalid", mk_in(0, 0, 16'h0010, 0, 0, 16'h0300, 16'h0000, 16'hA5A5),
        mk_out(0, 0, 1, 16'hA5A5, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    add("fetch_idle", mk_in(0, 0, 16'h0010, 0, 0, 16'h0300, 16'h0000, 16'hA5A5), '0);

    both_ld = mk_in(0, 1, 16'h0020, 1, 0, 16'h0300, 16'h0BAD, 16'h5A5A);
    for (int k = 0; k < 4; k++)
      add($sformatf("contend_d_%0d", k), both_ld,
          mk_out(0, 1, 0, 16'h0000, k > 0, (k > 0) ? 16'h5A5A : 16'h0000,
                 16'h0300, 16'h0BAD, 0, 1, 1, 0));
    add("contend_if_forced", both_ld,
        mk_out(1, 0, 0, 16'h0000, 1, 16'h5A5A, 16'h0020, 16'h0000, 0, 1, 0, 1));
    add("contend_d_after_if", both_ld,
        mk_out(0, 1, 1, 16'h5A5A, 0, 16'h0000, 16'h0300, 16'h0BAD, 0, 1, 1, 0));
    add("drain_load", mk_in(0, 0, 16'h0020, 0, 0, 16'h0300, 16'h0BAD, 16'h5A5A),
        mk_out(0, 0, 0, 16'h0000, 1, 16'h5A5A, 16'h0000, 16'h0000, 0, 0, 0, 0));
    add("store_grant", mk_in(0, 1, 16'h0020, 1, 1, 16'h0200, 16'h1234, 16'h5A5A),
        mk_out(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0200, 16'h1234, 1, 0, 1, 0));
    add("fetch_after_store", mk_in(0, 1, 16'h0020, 0, 1, 16'h0200, 16'h1234, 16'h5A5A),
        mk_out(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0020, 16'h0000, 0, 1, 0, 0));
    add("fetch_after_store_rv", mk_in(0, 0, 16'h0020, 0, 0, 16'h0200, 16'h1234, 16'h5A5A),
        mk_out(0, 0, 1, 16'h5A5A, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    add("idle_end", mk_in(0, 0, 16'h0020, 0, 0, 16'h0200, 16'h1234, 16'h5A5A), '0);

    foreach (vecs[i]) step(0, vecs[i].name, vecs[i].vin, vecs[i].vexp);

    // ------- Starvation counter clears when if_req drops (MEM_LAT = 1) -------
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drv = both_ld;
      drv.if_req = starve_if_pat[i];
      #1;
      check($sformatf("starve_clear_%0d", i), {act[0].if_gnt, act[0].d_gnt},
            {starve_exp_if[i], ~starve_exp_if[i]});
    end
    idle_in = mk_in(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5A5A);
    step(0, "starve_clear_rv", idle_in,
         mk_out(0, 0, 1, 16'h5A5A, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));

    // ------- Reset during an outstanding load (MEM_LAT = 3) -------
    step(1, "lat3_pre_reset", mk_in(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hC3C3), '0);
    step(1, "lat3_load_grant", mk_in(0, 0, 16'h0000, 1, 0, 16'h0400, 16'h0000, 16'hC3C3),
         mk_out(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0400, 16'h0000, 0, 1, 0, 0));
    step(1, "lat3_reset_a", mk_in(1, 0, 16'h0000, 0, 0, 16'h0400, 16'h0000, 16'hC3C3), '0);
    step(1, "lat3_reset_b", mk_in(1, 0, 16'h0000, 0, 0, 16'h0400, 16'h0000, 16'hC3C3), '0);
    step(1, "lat3_grant_after_reset",
         mk_in(0, 0, 16'h0000, 1, 0, 16'h0402, 16'h0000, 16'hC3C3),
         mk_out(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0402, 16'h0000, 0, 1, 0, 0));
    for (int k = 0; k < 2; k++)
      step(1, $sformatf("lat3_wait_%0d", k),
           mk_in(0, 0, 16'h0000, 0, 0, 16'h0402, 16'h0000, 16'hC3C3),
           mk_out(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1));
    step(1, "lat3_rvalid", mk_in(0, 0, 16'h0000, 0, 0, 16'h0402, 16'h0000, 16'hC3C3),
         mk_out(0, 0, 0, 16'h0000, 1, 16'hC3C3, 16'h0000, 16'h0000, 0, 0, 0, 0));
    step(1, "lat3_idle", mk_in(0, 0, 16'h0000, 0, 0, 16'h0402, 16'h0000, 16'hC3C3), '0);

    // ------- Load then fetch overlapping its last cycle (MEM_LAT = 2) -------
    step(2, "lat2_reset", mk_in(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h7E7E), '0);
    step(2, "lat2_load_grant", mk_in(0, 1, 16'h0030, 1, 0, 16'h0500, 16'h0000, 16'h7E7E),
         mk_out(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0500, 16'h0000, 0, 1, 1, 0));
    step(2, "lat2_busy", mk_in(0, 1, 16'h0030, 0, 0, 16'h0500, 16'h0000, 16'h7E7E),
         mk_out(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1));
    step(2, "lat2_rvalid_and_if_gnt", mk_in(0, 1, 16'h0030, 0, 0, 16'h0500, 16'h0000, 16'h7E7E),
         mk_out(1, 0, 0, 16'h0000, 1, 16'h7E7E, 16'h0030, 16'h0000, 0, 1, 0, 0));
    step(2, "lat2_fetch_wait", mk_in(0, 0, 16'h0030, 0, 0, 16'h0500, 16'h0000, 16'h7E7E),
         mk_out(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0));
    step(2, "lat2_if_rvalid", mk_in(0, 0, 16'h0030, 0, 0, 16'h0500, 16'h0000, 16'h7E7E),
         mk_out(0, 0, 1, 16'h7E7E, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    step(2, "lat2_idle", mk_in(0, 0, 16'h0030, 0, 0, 16'h0500, 16'h0000, 16'h7E7E), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
